// File: rtl/nibble_sort_ctrl_if.sv
// Valid/ready load and drain streams of the nibble sorter.
// The producer/consumer side is master, the sorter is slave.
interface nibble_sort_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             desc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output desc,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  desc,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/nibble_sort_ctrl.sv
// Burst nibble sorter: load, in-place bubble sort on one shared
// comparator with early exit, then drain in index order.
module nibble_sort_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_sort_ctrl_if.slave   bus,
    output logic                busy,
    output logic                sort_done,
    output logic [7:0]          swap_cnt
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_CMP = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     pass;
    logic              swapped;
    logic              order_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic [IW-1:0]     nxt;
    logic [WIDTH-1:0]  cmp_a;
    logic [WIDTH-1:0]  cmp_b;
    logic              a_gt_b;
    logic              a_lt_b;
    logic              swap_now;
    logic              pass_end;
    logic              exit_now;
    logic              in_fire;
    logic              out_fire;

    // Shared comparator and pass-termination decision.
    always_comb begin
        nxt      = idx + IW'(1);
        cmp_a    = mem[idx];
        cmp_b    = mem[nxt];
        a_gt_b   = cmp_a > cmp_b;
        a_lt_b   = cmp_a < cmp_b;
        swap_now = order_q ? a_lt_b : a_gt_b;
        pass_end = (idx == LAST_CMP);
        exit_now = (state == S_SORT) && pass_end &&
                   (!(swapped || swap_now) || (pass == LAST_CMP));
        in_fire  = bus.in_valid && in_ready_q;
        out_fire = out_valid_q && bus.out_ready;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? mem[rd_idx] : '0;
    assign busy          = busy_q;
    assign sort_done     = exit_now;

    // Sequencer: load, compare-and-swap one pair per cycle, drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            wr_idx      <= '0;
            rd_idx      <= '0;
            idx         <= '0;
            pass        <= '0;
            swapped     <= 1'b0;
            order_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            swap_cnt    <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        mem[wr_idx] <= bus.in_data;
                        if (wr_idx == '0) begin
                            order_q  <= bus.desc;
                            swap_cnt <= '0;
                        end
                        if (wr_idx == LAST_IDX) begin
                            state      <= S_SORT;
                            wr_idx     <= '0;
                            idx        <= '0;
                            pass       <= '0;
                            swapped    <= 1'b0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                S_SORT: begin
                    if (swap_now) begin
                        mem[idx] <= cmp_b;
                        mem[nxt] <= cmp_a;
                        if (swap_cnt != 8'hFF) begin
                            swap_cnt <= swap_cnt + 8'd1;
                        end
                    end
                    if (exit_now) begin
                        state       <= S_DRAIN;
                        idx         <= '0;
                        pass        <= '0;
                        swapped     <= 1'b0;
                        rd_idx      <= '0;
                        out_valid_q <= 1'b1;
                    end else if (pass_end) begin
                        idx     <= '0;
                        pass    <= pass + IW'(1);
                        swapped <= 1'b0;
                    end else begin
                        idx     <= nxt;
                        swapped <= swapped || swap_now;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        if (rd_idx == LAST_IDX) begin
                            state       <= S_LOAD;
                            rd_idx      <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Directed and randomized bursts for nibble_sort_ctrl, checked
// against a value-counting sort model with inversion-based timing.
module tb_nibble_sort_ctrl;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       sort_done;
    logic [7:0] swap_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_sort_ctrl_if bus ();

    nibble_sort_ctrl #(
        .DEPTH(DEPTH),
        .WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .sort_done(sort_done),
        .swap_cnt (swap_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sorted order by counting values, swaps = strict
    // inversions, passes = deepest left displacement + 1 (capped).
    task automatic ref_model(input logic [3:0] d [DEPTH], input bit dsc,
                             output logic [3:0] srt [DEPTH],
                             output int swaps, output int cycles);
        int n;
        int maxleft;
        int passes;
        n = 0;
        for (int v = 0; v < 16; v++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (int'(d[j]) == (dsc ? 15 - v : v)) begin
                    srt[n] = d[j];
                    n++;
                end
            end
        end
        swaps = 0;
        maxleft = 0;
        for (int m = 0; m < DEPTH; m++) begin
            int left;
            left = 0;
            for (int j = 0; j < m; j++) begin
                if (dsc ? (d[j] < d[m]) : (d[j] > d[m])) left++;
            end
            swaps += left;
            if (left > maxleft) maxleft = left;
        end
        if (swaps > 255) swaps = 255;
        passes = (maxleft + 1 < DEPTH - 1) ? maxleft + 1 : DEPTH - 1;
        cycles = passes * (DEPTH - 1);
    endtask

    task automatic load(input logic [3:0] d [DEPTH], input bit dsc,
                        input bit gaps, input bit toggle);
        int  k;
        int  g;
        bit  fire;
        k = 0;
        g = 0;
        bus.desc = dsc;
        while (k < DEPTH && g < 1000) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 4'($urandom_range(0, 15));
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = d[k];
            end
            fire = bus.in_valid && bus.in_ready;
            step();
            g++;
            if (fire) k++;
            if (toggle && k >= 1) bus.desc = ~bus.desc;
        end
        bus.in_valid = 1'b0;
        chk("load_count", k, DEPTH);
    endtask

    task automatic sort_phase(output int cyc, output int pulses);
        int g;
        cyc = 0;
        pulses = 0;
        g = 0;
        while (!bus.out_valid && g < 300) begin
            chk("in_ready_sort", bus.in_ready, 0);
            if (busy) cyc++;
            if (sort_done) pulses++;
            step();
            g++;
        end
        chk("sort_timeout", bus.out_valid, 1);
        chk("sort_done_drain", sort_done, 0);
    endtask

    task automatic drain(input logic [3:0] exp [DEPTH], input bit stalls);
        int         k;
        int         g;
        bit         prev_stall;
        logic [3:0] prev_d;
        k = 0;
        g = 0;
        prev_stall = 0;
        prev_d = '0;
        while (k < DEPTH && g < 1000) begin
            bus.out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("in_ready_drain", bus.in_ready, 0);
            chk("out_valid_drain", bus.out_valid, 1);
            chk("busy_drain", busy, 1);
            if (prev_stall) chk("out_stable", bus.out_data, prev_d);
            if (bus.out_ready) begin
                chk("out_data", bus.out_data, exp[k]);
                k++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                prev_d = bus.out_data;
            end
            step();
            g++;
        end
        bus.out_ready = 1'b0;
        chk("drain_count", k, DEPTH);
        chk("out_valid_after", bus.out_valid, 0);
        chk("busy_after", busy, 0);
        chk("in_ready_after", bus.in_ready, 1);
    endtask

    task automatic run_burst(input logic [3:0] d [DEPTH], input bit dsc,
                             input bit gaps, input bit stalls,
                             input bit toggle, input bit hold,
                             input logic [3:0] hold_d);
        logic [3:0] srt [DEPTH];
        int         swaps;
        int         cycles;
        int         cyc;
        int         pulses;
        ref_model(d, dsc, srt, swaps, cycles);
        load(d, dsc, gaps, toggle);
        sort_phase(cyc, pulses);
        chk("sort_cycles", cyc, cycles);
        chk("sort_done_pulses", pulses, 1);
        chk("swap_cnt", swap_cnt, swaps);
        if (hold) begin
            bus.in_valid = 1'b1;
            bus.in_data  = hold_d;
        end
        drain(srt, stalls);
        chk("swap_cnt_hold", swap_cnt, swaps);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] d [DEPTH];
        logic [3:0] d2 [DEPTH];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h5;
        bus.desc      = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sort_done", sort_done, 0);
        chk("rst_swap_cnt", swap_cnt, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", bus.in_ready, 1);

        d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        run_burst(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        d = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        run_burst(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        d = '{4'h3, 4'h9, 4'h3, 4'h0, 4'hF, 4'h9, 4'h1, 4'h3};
        run_burst(d, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < DEPTH; j++) d[j] = 4'($urandom_range(0, 15));
            run_burst(d, 1'($urandom_range(0, 1)), 1'b1, 1'b1,
                      1'b1, 1'b0, 4'd0);
        end

        d = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
        load(d, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("mid_sort_busy", busy, 1);
        rst_n = 1'b0;
        step();
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_data", bus.out_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sort_done", sort_done, 0);
        chk("abort_swap_cnt", swap_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("abort_rel_in_ready", bus.in_ready, 1);
        d[0] = 4'd2;
        d[1] = 4'd1;
        for (int j = 2; j < DEPTH; j++) d[j] = 4'($urandom_range(0, 15));
        run_burst(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        for (int j = 0; j < DEPTH; j++) begin
            d[j]  = 4'($urandom_range(0, 15));
            d2[j] = 4'($urandom_range(0, 15));
        end
        run_burst(d, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, d2[0]);
        run_burst(d2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
